// File: rtl/param_seq_detector_pkg.sv
// ----------------------------------------------------------------------------
// seq_det_pkg
//   Shared types and helpers for the parametrised serial pattern detector.
//   - state_t     : detector FSM states (2-bit encoding)
//   - LEN_W       : length-field width for the default PAT_W of 8
//   - masked_eq   : compares the low 'len' bits of two vectors
//   - clamp_len   : limits a requested length to the history depth
// ----------------------------------------------------------------------------
package seq_det_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ARMED = 2'd1,
        HIT   = 2'd2,
        LOCK  = 2'd3
    } state_t;

    localparam int DEF_PAT_W = 8;
    localparam int LEN_W     = $clog2(DEF_PAT_W + 1);

    // Widest pattern the compare helper supports; callers zero-extend.
    localparam int MAX_W = 32;

    function automatic logic masked_eq(input logic [MAX_W-1:0] a,
                                       input logic [MAX_W-1:0] b,
                                       input int unsigned      len);
        logic [MAX_W-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            mask[i] = (i < len);
        end
        return ((a ^ b) & mask) == '0;
    endfunction

    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/param_seq_detector_if.sv
// ----------------------------------------------------------------------------
// param_seq_detector_if
//   Serial input, configuration and status bundle of param_seq_detector.
//   master : bit source / configuration side (drives in_bit, in_valid, cfg_*,
//            clear; observes match, match_cnt, armed)
//   slave  : the detector
// ----------------------------------------------------------------------------
interface param_seq_detector_if #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8
);
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic             in_bit;
    logic             in_valid;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             cfg_sticky;
    logic             clear;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             armed;

    modport master (
        output in_bit, in_valid, cfg_load, cfg_pattern, cfg_len,
               cfg_overlap, cfg_sticky, clear,
        input  match, match_cnt, armed
    );

    modport slave (
        input  in_bit, in_valid, cfg_load, cfg_pattern, cfg_len,
               cfg_overlap, cfg_sticky, clear,
        output match, match_cnt, armed
    );

endinterface

// File: rtl/param_seq_detector_hist.sv
// ----------------------------------------------------------------------------
// seq_det_hist
//   Bit history shift register, fill counter and masked pattern comparator.
//   Ports:
//     clk, reset_n  clock, async active-low reset
//     in_bit        serial data bit
//     shift_en      accept in_bit this cycle
//     flush         clear history and fill (configuration load)
//     overlap       1 = keep fill after a hit, 0 = restart fill
//     pat, len      active pattern and (clamped) length
//     hit           next-state history completes the pattern
//     fill          current number of valid history bits (saturating)
//     fill_nxt      fill value loaded at the coming edge
// ----------------------------------------------------------------------------
module seq_det_hist
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_bit,
    input  logic                         shift_en,
    input  logic                         flush,
    input  logic                         overlap,
    input  logic [PAT_W-1:0]             pat,
    input  logic [$clog2(PAT_W+1)-1:0]   len,
    output logic                         hit,
    output logic [$clog2(PAT_W+1)-1:0]   fill,
    output logic [$clog2(PAT_W+1)-1:0]   fill_nxt
);
    localparam int LW = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] hist_q;
    logic [PAT_W-1:0] hist_nxt;
    logic [LW-1:0]    fill_q;
    logic [LW-1:0]    fill_inc;

    always_comb begin
        hist_nxt = hist_q;
        fill_inc = fill_q;
        if (shift_en) begin
            hist_nxt = {hist_q[PAT_W-2:0], in_bit};
            fill_inc = (fill_q == LW'(PAT_W)) ? fill_q : fill_q + 1'b1;
        end
    end

    // A hit needs a freshly accepted bit, otherwise a matching history would
    // re-trigger every idle cycle.
    always_comb begin
        hit = shift_en && (len != '0) && (fill_inc >= len) &&
              masked_eq(MAX_W'(hist_nxt), MAX_W'(pat), int'(len));
    end

    always_comb begin
        fill_nxt = fill_inc;
        if (flush || (hit && !overlap)) begin
            fill_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= flush ? '0 : hist_nxt;
            fill_q <= fill_nxt;
        end
    end

    assign fill = fill_q;

endmodule

// File: rtl/param_seq_detector.sv
// ----------------------------------------------------------------------------
// param_seq_detector
//   Moore serial pattern detector with runtime pattern/length, input
//   qualifier, overlap/non-overlap, pulse/sticky match and saturating counter.
//   Ports:
//     clk      system clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      param_seq_detector_if.slave (in_bit, in_valid, cfg_*, clear,
//              match, match_cnt, armed)
// ----------------------------------------------------------------------------
module param_seq_detector
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 8,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(9),
    parameter int               DEF_LEN = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    param_seq_detector_if.slave  bus
);
    localparam int LW = $clog2(PAT_W + 1);

    state_t           state_q;
    state_t           state_d;
    logic [PAT_W-1:0] pat_q;
    logic [LW-1:0]    len_q;
    logic [CNT_W-1:0] cnt_q;
    logic             hit;
    logic [LW-1:0]    fill;
    logic [LW-1:0]    fill_nxt;
    state_t           settle;

    seq_det_hist #(
        .PAT_W (PAT_W)
    ) u_hist (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_bit   (bus.in_bit),
        .shift_en (bus.in_valid && !bus.cfg_load),
        .flush    (bus.cfg_load),
        .overlap  (bus.cfg_overlap),
        .pat      (pat_q),
        .len      (len_q),
        .hit      (hit),
        .fill     (fill),
        .fill_nxt (fill_nxt)
    );

    // Configuration registers; length is stored already clamped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_q <= DEF_PAT;
            len_q <= LW'(clamp_len(DEF_LEN, PAT_W));
        end else if (bus.cfg_load) begin
            pat_q <= bus.cfg_pattern;
            len_q <= LW'(clamp_len(int'(bus.cfg_len), PAT_W));
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Leaving HIT/LOCK lands in ARMED or FILL depending on
    // the fill level, which already reflects the overlap setting.
    always_comb begin
        settle  = (fill_nxt >= len_q) ? ARMED : FILL;
        state_d = state_q;
        if (bus.cfg_load || (len_q == '0)) begin
            state_d = FILL;
        end else if (hit) begin
            state_d = (bus.cfg_sticky || state_q == LOCK) ? LOCK : HIT;
        end else begin
            unique case (state_q)
                FILL, ARMED: state_d = settle;
                HIT:         state_d = (bus.cfg_sticky && !bus.clear) ? LOCK : settle;
                LOCK:        state_d = bus.clear ? settle : LOCK;
                default:     state_d = FILL;
            endcase
        end
    end

    // Outputs
    always_comb begin
        bus.match     = (state_q == HIT) || (state_q == LOCK);
        bus.armed     = (len_q != '0) && (fill >= len_q);
        bus.match_cnt = cnt_q;
    end

    // Saturating match counter; a hit in the same cycle as clear restarts at 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (bus.cfg_load) begin
            cnt_q <= '0;
        end else if (hit) begin
            if (bus.clear) begin
                cnt_q <= CNT_W'(1);
            end else if (!(&cnt_q)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else if (bus.clear) begin
            cnt_q <= '0;
        end
    end

endmodule

// File: tb/tb_param_seq_detector.sv
// ----------------------------------------------------------------------------
// tb_param_seq_detector
//   Directed bench for param_seq_detector: a default instance (CNT_W=8) and a
//   narrow-counter instance (CNT_W=2). Each stimulus cycle pushes its expected
//   outputs onto a queue; the entry is popped and compared after the edge.
// ----------------------------------------------------------------------------
module tb_param_seq_detector;

    logic clk;
    logic reset_n;

    param_seq_detector_if #(.PAT_W(8), .CNT_W(8)) bus  ();
    param_seq_detector_if #(.PAT_W(8), .CNT_W(2)) bus2 ();

    param_seq_detector #(.PAT_W(8), .CNT_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    param_seq_detector #(.PAT_W(8), .CNT_W(2)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic  m;
        int    c;
        logic  a;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock of stimulus on instance sel (0 = bus, 1 = bus2).
    task automatic cycle(input int sel, input logic ld, input logic [7:0] p,
                         input logic [3:0] l, input logic b, input logic v,
                         input logic c, input logic em, input int ec,
                         input logic ea, input string tag);
        exp_t e;
        @(negedge clk);
        if (sel == 0) begin
            bus.cfg_load = ld; bus.cfg_pattern = p; bus.cfg_len = l;
            bus.in_bit = b; bus.in_valid = v; bus.clear = c;
        end else begin
            bus2.cfg_load = ld; bus2.cfg_pattern = p; bus2.cfg_len = l;
            bus2.in_bit = b; bus2.in_valid = v; bus2.clear = c;
        end
        exp_q.push_back('{m: em, c: ec, a: ea, tag: tag});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (sel == 0) begin
            check({e.tag, ".match"}, 32'(bus.match), 32'(e.m));
            check({e.tag, ".cnt"},   32'(bus.match_cnt), 32'(e.c));
            check({e.tag, ".armed"}, 32'(bus.armed), 32'(e.a));
            bus.cfg_load = 1'b0; bus.in_valid = 1'b0; bus.clear = 1'b0;
        end else begin
            check({e.tag, ".match"}, 32'(bus2.match), 32'(e.m));
            check({e.tag, ".cnt"},   32'(bus2.match_cnt), 32'(e.c));
            check({e.tag, ".armed"}, 32'(bus2.armed), 32'(e.a));
            bus2.cfg_load = 1'b0; bus2.in_valid = 1'b0; bus2.clear = 1'b0;
        end
    endtask

    task automatic st(input logic b, input logic v, input logic c,
                      input logic em, input int ec, input logic ea, input string tag);
        cycle(0, 1'b0, 8'h00, 4'd0, b, v, c, em, ec, ea, tag);
    endtask

    task automatic ld(input logic [7:0] p, input logic [3:0] l, input string tag);
        cycle(0, 1'b1, p, l, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, tag);
    endtask

    initial begin
        reset_n = 1'b0;
        bus.in_bit = 0;  bus.in_valid = 0;  bus.cfg_load = 0;  bus.cfg_pattern = '0;
        bus.cfg_len = '0; bus.cfg_overlap = 1; bus.cfg_sticky = 0; bus.clear = 0;
        bus2.in_bit = 0; bus2.in_valid = 0; bus2.cfg_load = 0; bus2.cfg_pattern = '0;
        bus2.cfg_len = '0; bus2.cfg_overlap = 1; bus2.cfg_sticky = 0; bus2.clear = 0;

        repeat (2) @(negedge clk);
        check("rst.match", 32'(bus.match), 0);
        check("rst.cnt",   32'(bus.match_cnt), 0);
        check("rst.armed", 32'(bus.armed), 0);
        reset_n = 1'b1;

        // 1: default pattern 1001 / len 4
        st(1, 1, 0, 0, 0, 0, "t1.b1");
        st(0, 1, 0, 0, 0, 0, "t1.b2");
        st(0, 1, 0, 0, 0, 0, "t1.b3");
        st(1, 1, 0, 1, 1, 1, "t1.b4");
        st(0, 0, 0, 0, 1, 1, "t1.idle");

        // 2: pattern 1101, overlapping
        ld(8'b1101, 4'd4, "t2.ld");
        st(1, 1, 0, 0, 0, 0, "t2o.b1");
        st(1, 1, 0, 0, 0, 0, "t2o.b2");
        st(0, 1, 0, 0, 0, 0, "t2o.b3");
        st(1, 1, 0, 1, 1, 1, "t2o.b4");
        st(1, 1, 0, 0, 1, 1, "t2o.b5");
        st(0, 1, 0, 0, 1, 1, "t2o.b6");
        st(1, 1, 0, 1, 2, 1, "t2o.b7");
        st(0, 0, 0, 0, 2, 1, "t2o.idle");
        // 2: same stream, non-overlapping
        bus.cfg_overlap = 1'b0;
        ld(8'b1101, 4'd4, "t2n.ld");
        st(1, 1, 0, 0, 0, 0, "t2n.b1");
        st(1, 1, 0, 0, 0, 0, "t2n.b2");
        st(0, 1, 0, 0, 0, 0, "t2n.b3");
        st(1, 1, 0, 1, 1, 0, "t2n.b4");
        st(1, 1, 0, 0, 1, 0, "t2n.b5");
        st(0, 1, 0, 0, 1, 0, "t2n.b6");
        st(1, 1, 0, 0, 1, 0, "t2n.b7");
        st(0, 0, 0, 0, 1, 0, "t2n.idle");

        // 3: sticky, clear, clear coincident with a hit
        bus.cfg_overlap = 1'b1;
        bus.cfg_sticky  = 1'b1;
        ld(8'b1001, 4'd4, "t3.ld");
        st(1, 1, 0, 0, 0, 0, "t3.b1");
        st(0, 1, 0, 0, 0, 0, "t3.b2");
        st(0, 1, 0, 0, 0, 0, "t3.b3");
        st(1, 1, 0, 1, 1, 1, "t3.b4");
        for (int i = 0; i < 4; i++) st(0, 1, 0, 1, 1, 1, "t3.zero");
        st(0, 0, 1, 0, 0, 1, "t3.clr");
        st(1, 1, 0, 0, 0, 1, "t3.c1");
        st(0, 1, 0, 0, 0, 1, "t3.c2");
        st(0, 1, 0, 0, 0, 1, "t3.c3");
        st(1, 1, 1, 1, 1, 1, "t3.clrhit");
        bus.cfg_sticky = 1'b0;
        st(0, 0, 1, 0, 0, 1, "t3.clr2");

        // 4: in_valid gaps
        ld(8'b1001, 4'd4, "t4.ld");
        st(1, 1, 0, 0, 0, 0, "t4.b1");
        st(0, 1, 0, 0, 0, 0, "t4.b2");
        for (int i = 0; i < 3; i++) st(1, 0, 0, 0, 0, 0, "t4.gap");
        st(0, 1, 0, 0, 0, 0, "t4.b3");
        st(1, 1, 0, 1, 1, 1, "t4.b4");
        st(0, 0, 0, 0, 1, 1, "t4.idle");

        // 5: 2-bit counter saturation on the narrow instance
        cycle(1, 1'b1, 8'b11, 4'd2, 1, 1, 0, 0, 0, 0, "t5.ld");
        cycle(1, 1'b0, 8'h00, 4'd0, 1, 1, 0, 0, 0, 0, "t5.b1");
        cycle(1, 1'b0, 8'h00, 4'd0, 1, 1, 0, 1, 1, 1, "t5.b2");
        cycle(1, 1'b0, 8'h00, 4'd0, 1, 1, 0, 1, 2, 1, "t5.b3");
        cycle(1, 1'b0, 8'h00, 4'd0, 1, 1, 0, 1, 3, 1, "t5.b4");
        for (int i = 0; i < 4; i++)
            cycle(1, 1'b0, 8'h00, 4'd0, 1, 1, 0, 1, 3, 1, "t5.sat");
        cycle(1, 1'b0, 8'h00, 4'd0, 0, 0, 0, 0, 3, 1, "t5.idle");

        // 6a: len = 0 disables detection, even for an all-zero stream
        ld(8'h00, 4'd0, "t6a.ld");
        for (int i = 0; i < 4; i++) st(0, 1, 0, 0, 0, 0, "t6a.b");

        // 6b: len = 12 clamps to 8; pattern A5 sent MSB first
        begin
            logic [7:0] p;
            p = 8'hA5;
            ld(p, 4'd12, "t6b.ld");
            for (int i = 7; i >= 1; i--) st(p[i], 1, 0, 0, 0, 0, "t6b.b");
            st(p[0], 1, 0, 1, 1, 1, "t6b.last");
        end

        // 6c: reset mid-sequence discards history
        ld(8'b1001, 4'd4, "t6c.ld");
        st(1, 1, 0, 0, 0, 0, "t6c.b1");
        st(0, 1, 0, 0, 0, 0, "t6c.b2");
        st(0, 1, 0, 0, 0, 0, "t6c.b3");
        st(1, 1, 0, 1, 1, 1, "t6c.b4");
        st(1, 1, 0, 0, 1, 1, "t6c.b5");
        st(0, 1, 0, 0, 1, 1, "t6c.b6");
        st(0, 1, 0, 0, 1, 1, "t6c.b7");
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t6c.rst.match", 32'(bus.match), 0);
        check("t6c.rst.cnt",   32'(bus.match_cnt), 0);
        check("t6c.rst.armed", 32'(bus.armed), 0);
        @(negedge clk);
        reset_n = 1'b1;
        st(1, 1, 0, 0, 0, 0, "t6c.lone1");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/param_seq_detector.md
Name: param_seq_detector

Overview:
- Parametrised Moore-style serial pattern detector. Next generation of the team's fixed 4-bit sequence detector.
- Pattern and length are runtime-configurable up to PAT_W bits.
- Adds an input qualifier, overlap and non-overlap modes, pulse and sticky output modes, and a saturating match counter.
- Sits between a serial bit source and status/interrupt logic.

Parameters:
- PAT_W, 8, maximum pattern length in bits (>=2).
- CNT_W, 8, width of the match counter.
- DEF_PAT, 8'b0000_1001, pattern loaded at reset (LSB-aligned).
- DEF_LEN, 4, pattern length loaded at reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_bit  in  1  serial data bit.
- in_valid  in  1  in_bit is sampled only when high.
- cfg_load  in  1  one-cycle strobe; latches cfg_pattern/cfg_len.
- cfg_pattern  in  PAT_W  pattern, LSB-aligned; bit[len-1] is the first bit received, bit[0] the last.
- cfg_len  in  $clog2(PAT_W+1)  active pattern length.
- cfg_overlap  in  1  1 = overlapping matches allowed.
- cfg_sticky  in  1  1 = match latches until clear.
- clear  in  1  clears the match flag and match_cnt.
- match  out  1  registered match flag (Moore: a function of state only).
- match_cnt  out  CNT_W  saturating count of matches.
- armed  out  1  history holds at least len valid bits.

Behaviour:
- Reset (asynchronous, on reset_n low):
  - hist=0, fill=0, state=FILL, match=0, match_cnt=0, armed=0.
  - Pattern register=DEF_PAT, length register=DEF_LEN.
- Config registers: pattern and len are latched only on cfg_load. cfg_overlap and cfg_sticky are live inputs, sampled every cycle.
- Length rules: len > PAT_W is clamped to PAT_W. len = 0 disables detection (state held in FILL, match never set).
- History update, only when in_valid=1 and cfg_load=0:
  - hist <= {hist[PAT_W-2:0], in_bit}
  - fill <= min(fill+1, PAT_W)
- Hit condition: computed on the next-state history as fill_next >= len and hist_next[len-1:0] == pat[len-1:0].
- States:
  - FILL: fill < len. Goes to ARMED when fill reaches len without a hit; goes to HIT on a hit.
  - ARMED: history full. Goes to HIT on a hit; otherwise stays.
  - HIT: match=1 for exactly one cycle.
    - Next state on no new hit is ARMED (overlap) or FILL (non-overlap).
    - A back-to-back hit in overlap mode re-enters HIT.
    - If cfg_sticky=1, goes to LOCK instead.
  - LOCK: match held at 1. Detection continues and match_cnt still increments. Leaves to ARMED/FILL only on clear.
- Non-overlap: on a hit, fill_next is forced to 0. The next match needs len fresh bits.
- Latency: match rises on the clock edge that samples the final pattern bit, so it is visible the cycle after in_bit/in_valid.
- Counter: match_cnt increments by 1 per hit and saturates at 2^CNT_W-1 (no wrap).
- Clear:
  - Zeroes match_cnt. Moves LOCK/HIT to ARMED or FILL according to fill. Does not touch hist.
  - Clear and a hit in the same cycle: the hit wins. State=HIT/LOCK, match_cnt=1.
- cfg_load:
  - Has priority over everything. Clears hist, fill, match, match_cnt; state=FILL.
  - in_valid is ignored in that cycle.
- armed = (fill >= len) && (len != 0).
- Reset mid-sequence: all partial history is discarded immediately. Outputs read 0 while reset_n=0.

Decomposition:
- Shared package seq_det_pkg:
  - state enum {FILL, ARMED, HIT, LOCK}, 2-bit encoding.
  - Localparam LEN_W = $clog2(PAT_W+1).
  - Masked-compare function.
- One natural sub-module, seq_det_hist: shift register, fill counter and masked comparator, outputting hit and fill. The top level holds the FSM, counter and config registers.

Test Plan:
1. Defaults after reset, stream 1,0,0,1 with in_valid=1 throughout -> match=1 for one cycle after the 4th bit, match_cnt=1, armed=1.
2. cfg_load pattern 4'b1101, len=4, overlap=1; stream 1,1,0,1,1,0,1 -> two one-cycle match pulses (after bits 4 and 7), match_cnt=2. Repeat with overlap=0 -> one pulse only, match_cnt=1.
3. sticky=1, default pattern; stream 1001 then 0000 -> match stays 1 through the zeros. clear pulse -> match=0, match_cnt=0. A clear coincident with a completing 1001 -> match=1, match_cnt=1.
4. in_valid gaps: 1,0,[in_valid=0 x3 with in_bit=1],0,1 -> exactly one match. Bits with in_valid=0 are ignored.
5. CNT_W=2, overlap=1, pattern 2'b11, len=2; stream eight 1s -> match_cnt saturates at 3 and stays 3.
6. Edge cases:
   - len=0 -> no match for any stream.
   - len=12 with PAT_W=8 -> behaves as len=8.
   - Assert reset_n=0 after 1,0,0 -> all outputs 0. After release, a lone 1 produces no match.
